// File: rtl/zkey_debouncer_if.sv
//==============================================================================
// Module      : zkey_debouncer_if
// Description : Key pad input and debounced press outputs of zkey_debouncer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface zkey_debouncer_if;
    logic       iKey_N;
    logic       oPressed;
    logic       oShortPulse;
    logic       oLongPulse;
    logic [7:0] oPressCnt;

    modport master (
        output iKey_N,
        input  oPressed,
        input  oShortPulse,
        input  oLongPulse,
        input  oPressCnt
    );

    modport slave (
        input  iKey_N,
        output oPressed,
        output oShortPulse,
        output oLongPulse,
        output oPressCnt
    );
endinterface

`default_nettype wire

// File: rtl/zkey_debouncer.sv
//==============================================================================
// Module      : zkey_debouncer
// Description : Synchronises and debounces an active-low key; short/long press.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module zkey_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 150_000_000
) (
    input  wire logic         iClk,
    input  wire logic         iRst_N,
    zkey_debouncer_if.slave   key_if
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES + 1);

    // The cycle in which the edge is first seen counts as stable cycle one,
    // so the debounce counter only has to reach DEBOUNCE_CYCLES-2.
    localparam logic [DW-1:0] c_DB_LAST   = DW'(DEBOUNCE_CYCLES - 2);
    localparam logic [HW-1:0] c_LONG_FIRE = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] c_LONG_SAT  = HW'(LONG_CYCLES);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    state_t          state_q;
    logic            s1_q;
    logic            s2_q;
    logic [DW-1:0]   dcnt_q;
    logic [HW-1:0]   hcnt_q;
    logic            long_fired_q;
    logic            pressed_q;
    logic            short_q;
    logic            long_q;
    logic [7:0]      press_cnt_q;
    logic [HW-1:0]   hcnt_d;

    // Saturating hold count; registering the pulse on hcnt_d keeps it aligned
    // with the cycle in which the hold reaches LONG_CYCLES.
    assign hcnt_d = (hcnt_q == c_LONG_SAT) ? hcnt_q : hcnt_q + 1'b1;

    always_ff @(posedge iClk) begin
        if (!iRst_N) begin
            state_q      <= IDLE;
            s1_q         <= 1'b1;
            s2_q         <= 1'b1;
            dcnt_q       <= '0;
            hcnt_q       <= '0;
            long_fired_q <= 1'b0;
            pressed_q    <= 1'b0;
            short_q      <= 1'b0;
            long_q       <= 1'b0;
            press_cnt_q  <= 8'd0;
        end else begin
            s1_q    <= key_if.iKey_N;
            s2_q    <= s1_q;
            short_q <= 1'b0;
            long_q  <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (!s2_q) begin
                        state_q <= PRESS_DB;
                        dcnt_q  <= '0;
                    end
                end
                PRESS_DB: begin
                    if (s2_q) begin
                        state_q <= IDLE;
                        dcnt_q  <= '0;
                    end else if (dcnt_q == c_DB_LAST) begin
                        state_q      <= HELD;
                        pressed_q    <= 1'b1;
                        press_cnt_q  <= press_cnt_q + 8'd1;
                        hcnt_q       <= '0;
                        long_fired_q <= 1'b0;
                    end else begin
                        dcnt_q <= dcnt_q + 1'b1;
                    end
                end
                HELD: begin
                    if (s2_q) begin
                        state_q <= RELEASE_DB;
                        dcnt_q  <= '0;
                    end else begin
                        hcnt_q <= hcnt_d;
                        if (hcnt_d == c_LONG_FIRE && !long_fired_q) begin
                            long_q       <= 1'b1;
                            long_fired_q <= 1'b1;
                        end
                    end
                end
                RELEASE_DB: begin
                    // A cycle seen low again is a held cycle, so only the
                    // high cycles of a bounce freeze the hold count.
                    if (!s2_q) begin
                        state_q <= HELD;
                        hcnt_q  <= hcnt_d;
                        if (hcnt_d == c_LONG_FIRE && !long_fired_q) begin
                            long_q       <= 1'b1;
                            long_fired_q <= 1'b1;
                        end
                    end else if (dcnt_q == c_DB_LAST) begin
                        state_q   <= IDLE;
                        pressed_q <= 1'b0;
                        short_q   <= !long_fired_q;
                    end else begin
                        dcnt_q <= dcnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign key_if.oPressed    = pressed_q;
    assign key_if.oShortPulse = short_q;
    assign key_if.oLongPulse  = long_q;
    assign key_if.oPressCnt   = press_cnt_q;

endmodule

`default_nettype wire
